mmio_arbiter: RTL and testbench

MMIO_ARBITER -- requirements
Module: mmio_arbiter

---
 rtl/mmio_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mmio_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mmio_arbiter
// Description : Two-requester round-robin arbiter onto a single MMIO bus, with
//               decode-miss and timeout error completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    // requester 0 (CPU load/store)
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    // requester 1 (loader/debug)
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    // shared MMIO bus
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_work,
    input  logic        mmio_done,
    input  logic [31:0] mmio_read_data,
    // status
    output logic        grant,
    output logic        busy
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic        last_q,    last_d;
    logic        grant_q,   grant_d;
    logic        is_read_q, is_read_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        err_q,     err_d;

    logic w_req0;
    logic w_req1;
    logic w_win;
    logic w_active;
    logic w_resp;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;
    // On a tie the requester not served last wins; otherwise whoever asks.
    assign w_win  = (w_req0 && w_req1) ? ~last_q : w_req1;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            is_read_q <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cnt_q     <= 8'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    grant_d   = w_win;
                    last_d    = w_win;
                    addr_d    = w_win ? m1_addr  : m0_addr;
                    wdata_d   = w_win ? m1_wdata : m0_wdata;
                    is_read_d = w_win ? m1_read  : m0_read;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = 8'd0;
                if (mmio_work) begin
                    state_d = S_WAIT;
                end else begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // A completion landing on the timeout cycle still counts as success.
                if (mmio_done) begin
                    rdata_d = is_read_q ? mmio_read_data : 32'd0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_d >= C_TIMEOUT) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_active        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign w_resp          = (state_q == S_RESP);

    assign mmio_read       = w_active &  is_read_q;
    assign mmio_write      = w_active & ~is_read_q;
    assign mmio_addr       = w_active ? addr_q  : 32'd0;
    assign mmio_write_data = w_active ? wdata_q : 32'd0;

    assign m0_done         = w_resp & ~grant_q;
    assign m0_err          = m0_done & err_q;
    assign m0_rdata        = m0_done ? rdata_q : 32'd0;
    assign m1_done         = w_resp & grant_q;
    assign m1_err          = m1_done & err_q;
    assign m1_rdata        = m1_done ? rdata_q : 32'd0;

    assign grant           = grant_q;
    assign busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmio_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mmio_arbiter
// Description : Scoreboard bench for mmio_arbiter with a behavioural MMIO slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_arbiter;

    localparam int TIMEOUT = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        m0_read = 1'b0, m0_write = 1'b0;
    logic [31:0] m0_addr = '0,   m0_wdata = '0;
    logic        m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m1_addr = '0,   m1_wdata = '0;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mmio_read, mmio_write;
    logic [31:0] mmio_addr, mmio_write_data;
    logic        mmio_work = 1'b0;
    logic        mmio_done = 1'b0;
    logic [31:0] mmio_read_data = '0;
    logic        grant, busy;

    mmio_arbiter #(.TIMEOUT(TIMEOUT)) u_dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
        .mmio_write_data(mmio_write_data), .mmio_work(mmio_work), .mmio_done(mmio_done),
        .mmio_read_data(mmio_read_data), .grant(grant), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // slave behaviour knobs (written by stimulus only)
    logic        slave_work = 1'b0;
    int          slave_dly  = 1000;
    logic [31:0] slave_xor  = 32'hFFFF_0121;
    logic        exp_rd     = 1'b1;
    // slave bookkeeping (written by slave only)
    int          act_cnt    = 0;
    int          last_len   = 0;
    logic [31:0] first_addr = '0, first_wdata = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Slave: done on bus-active cycle slave_dly+1 (ISSUE is active cycle 1),
    // read data is address xor slave_xor.
    always @(negedge sys_clk) begin : slave
        if (mmio_read || mmio_write) begin
            act_cnt++;
            if (act_cnt == 1) begin
                first_addr  = mmio_addr;
                first_wdata = mmio_write_data;
            end else begin
                check_val("mmio_addr_stable", mmio_addr, first_addr);
                check_val("mmio_wdata_stable", mmio_write_data, first_wdata);
            end
            check_val("mmio_read_type", 32'(mmio_read), 32'(exp_rd));
            check_val("mmio_write_type", 32'(mmio_write), 32'(!exp_rd));
        end else begin
            if (act_cnt != 0) last_len = act_cnt;
            act_cnt = 0;
            check_val("mmio_idle_zero", mmio_addr | mmio_write_data, 32'd0);
        end
        mmio_work      = slave_work;
        mmio_done      = (act_cnt == slave_dly + 1);
        mmio_read_data = mmio_addr ^ slave_xor;
    end

    always @(negedge sys_clk) begin : monitor
        exp_t e;
        int   got;
        check_val("done_exclusive", 32'(m0_done & m1_done), 32'd0);
        if (m0_done || m1_done) begin
            got = m1_done ? 1 : 0;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("done_id", 32'(got), 32'(e.id));
                check_val("grant", 32'(grant), 32'(e.id));
                check_val("rdata", got == 1 ? m1_rdata : m0_rdata, e.rdata);
                check_val("err", 32'(got == 1 ? m1_err : m0_err), 32'(e.err));
                check_val("other_side_zero", got == 1 ? (m0_rdata | 32'(m0_err)) : (m1_rdata | 32'(m1_err)), 32'd0);
            end
        end else begin
            check_val("resp_outputs_zero", m0_rdata | m1_rdata | 32'({m0_err, m1_err}), 32'd0);
        end
    end

    task automatic drive_req(input int id, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            m0_read = rd; m0_write = wr; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_read = rd; m1_write = wr; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // One transaction from a single requester; exp_lat counts falling edges
    // from request to the done pulse, exp_len the cycles the bus is active.
    task automatic do_txn(input int id, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic work, input int dly, input logic exp_err,
                          input int exp_lat, input int exp_len);
        exp_t e;
        int   cyc;
        logic seen;
        check_val("busy_before_req", 32'(busy), 32'd0);
        slave_work = work;
        slave_dly  = dly;
        exp_rd     = rd;
        e.id    = id;
        e.err   = exp_err;
        e.rdata = (rd && !exp_err) ? (addr ^ slave_xor) : 32'd0;
        sb_q.push_back(e);
        drive_req(id, rd, wr, addr, wdata);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge sys_clk);
            cyc++;
            if (cyc == 1) drive_req(id, rd, wr, ~addr, ~wdata);
            seen = (id == 0) ? m0_done : m1_done;
        end
        drive_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("latency", 32'(cyc), 32'(exp_lat));
        @(negedge sys_clk);
        check_val("bus_active_cycles", 32'(last_len), 32'(exp_len));
    endtask

    initial begin : stim
        int   ndone;
        exp_t e;
        repeat (2) @(negedge sys_clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_bus", 32'({mmio_read, mmio_write, m0_done, m1_done}), 32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // read, slave done on WAIT cycle 2, data 0x1
        do_txn(0, 1'b1, 1'b0, 32'hFFFF_0120, 32'd0,           1'b1, 2,    1'b0, 4, 3);
        // minimum-latency write
        do_txn(1, 1'b0, 1'b1, 32'h4000_0010, 32'hCAFE_0001,   1'b1, 1,    1'b0, 3, 2);
        // decode miss: single ISSUE cycle, error
        do_txn(1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_1234,   1'b0, 1000, 1'b1, 2, 1);
        // read and write both high: read wins
        do_txn(0, 1'b1, 1'b1, 32'h2000_0004, 32'h0000_0055,   1'b1, 1,    1'b0, 3, 2);
        // timeout after TIMEOUT WAIT cycles
        do_txn(0, 1'b1, 1'b0, 32'h3000_0000, 32'd0,           1'b1, 1000, 1'b1, 6, 5);
        // done coincides with timeout: success
        do_txn(1, 1'b1, 1'b0, 32'h3000_0100, 32'd0,           1'b1, 4,    1'b0, 6, 5);
        // stray done during ISSUE is ignored, ends in timeout
        do_txn(0, 1'b1, 1'b0, 32'h5000_0000, 32'd0,           1'b1, 0,    1'b1, 6, 5);

        // reset in WAIT aborts without a done pulse
        slave_work = 1'b1;
        slave_dly  = 1000;
        exp_rd     = 1'b1;
        drive_req(1, 1'b1, 1'b0, 32'h6000_0000, 32'd0);
        repeat (3) @(negedge sys_clk);
        check_val("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_grant", 32'(grant), 32'd0);
        check_val("abort_bus", 32'({mmio_read, mmio_write}) | mmio_addr, 32'd0);
        check_val("abort_done", 32'({m0_done, m1_done}), 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // contention from reset: m0 first, then strict alternation
        slave_dly = 1;
        for (int i = 0; i < 4; i++) begin
            e.id    = i % 2;
            e.err   = 1'b0;
            e.rdata = (e.id == 0 ? 32'h1000_0000 : 32'h1000_0004) ^ slave_xor;
            sb_q.push_back(e);
        end
        drive_req(0, 1'b1, 1'b0, 32'h1000_0000, 32'd0);
        drive_req(1, 1'b1, 1'b0, 32'h1000_0004, 32'd0);
        ndone = 0;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            @(negedge sys_clk);
            if (m0_done || m1_done) ndone++;
        end
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check_val("contention_dones", 32'(ndone), 32'd4);
        repeat (3) @(negedge sys_clk);
        check_val("final_idle", 32'(busy), 32'd0);
        check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
